// File: rtl/lancer_de.sv
// lancer_de: dice roller. Latches die bounds on a button edge, runs a timed
// roll, then reduces a free-running 16-bit LFSR value modulo the span.
// Ports: clk, reset (async, active-high), lancer (roll button),
//   min_de/max_de (7-bit bounds), resultat (7-bit roll value),
//   valide (final roll held), occupe (ROULE or REDUIT in progress).
// Option: define LANCER_ANIM_EN to show tumbling values during ROULE.
module lancer_de #(
  parameter int          DUREE_ROULE = 1024,
  parameter logic [15:0] GRAINE      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lancer,
  input  logic [6:0] min_de,
  input  logic [6:0] max_de,
  output logic [6:0] resultat,
  output logic       valide,
  output logic       occupe
);

  localparam int CW =
    (DUREE_ROULE > 1) ? $clog2(DUREE_ROULE) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(DUREE_ROULE - 1);

  typedef enum logic [1:0] {
    REPOS,
    ROULE,
    REDUIT,
    AFFICHE
  } etat_t;

  etat_t        etat;
  etat_t        etat_suiv;
  logic [15:0]  lfsr;
  logic         lancer_q;
  logic         start;
  logic [CW-1:0] cnt;
  logic [6:0]   min_l;
  logic [6:0]   max_l;
  logic [7:0]   span;
  logic [13:0]  dvd;
  logic [7:0]   rem;
  logic [7:0]   rem_nx;
  logic         ge;
  logic [3:0]   pas;

`ifdef LANCER_ANIM_EN
  logic [5:0]   anim_cnt;
  logic [2:0]   anim_pas;
  logic         anim_act;
`endif

  assign start  = lancer & ~lancer_q;
  assign occupe = (etat == ROULE) || (etat == REDUIT);
  assign valide = (etat == AFFICHE);

  // Inverted bounds collapse to a single face: min_l.
  always_comb begin
    span = 8'd1;
    if (max_l >= min_l)
      span = 8'({1'b0, max_l} - {1'b0, min_l}) + 8'd1;
  end

  // One restoring-division step on the MSB of dvd.
  always_comb begin
    ge     = ({rem, dvd[13]} >= {1'b0, span});
    rem_nx = {rem[6:0], dvd[13]};
    if (ge)
      rem_nx = 8'({rem, dvd[13]} - {1'b0, span});
  end

  always_comb begin
    etat_suiv = etat;
    unique case (etat)
      REPOS:   if (start) etat_suiv = ROULE;
      ROULE:   if (cnt == '0) etat_suiv = REDUIT;
      REDUIT:  if (pas == 4'd13) etat_suiv = AFFICHE;
      AFFICHE: if (start) etat_suiv = ROULE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      etat     <= REPOS;
      lfsr     <= GRAINE;
      lancer_q <= 1'b0;
      cnt      <= '0;
      min_l    <= '0;
      max_l    <= '0;
      dvd      <= '0;
      rem      <= '0;
      pas      <= '0;
      resultat <= '0;
`ifdef LANCER_ANIM_EN
      anim_cnt <= '0;
      anim_pas <= '0;
      anim_act <= 1'b0;
`endif
    end else begin
      etat     <= etat_suiv;
      lfsr     <= {1'b0, lfsr[15:1]}
                ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      lancer_q <= lancer;
      unique case (etat)
        REPOS, AFFICHE: begin
          if (start) begin
            min_l    <= min_de;
            max_l    <= max_de;
            cnt      <= CNT_INIT;
            resultat <= '0;
`ifdef LANCER_ANIM_EN
            anim_cnt <= '0;
            anim_act <= 1'b0;
`endif
          end
        end
        ROULE: begin
          if (cnt == '0) begin
            dvd <= lfsr[13:0];
            rem <= '0;
            pas <= '0;
`ifdef LANCER_ANIM_EN
            anim_act <= 1'b0;
`endif
          end else begin
            cnt <= cnt - 1'b1;
`ifdef LANCER_ANIM_EN
            anim_cnt <= anim_cnt + 6'd1;
            if (anim_act) begin
              dvd      <= {dvd[12:0], 1'b0};
              rem      <= rem_nx;
              anim_pas <= anim_pas + 3'd1;
              if (anim_pas == 3'd6) begin
                anim_act <= 1'b0;
                resultat <= 7'(min_l + rem_nx);
              end
            end else if (anim_cnt == 6'd63) begin
              dvd      <= {lfsr[6:0], 7'b0};
              rem      <= '0;
              anim_pas <= '0;
              anim_act <= 1'b1;
            end
`endif
          end
        end
        REDUIT: begin
          dvd <= {dvd[12:0], 1'b0};
          rem <= rem_nx;
          pas <= pas + 4'd1;
          if (pas == 4'd13)
            resultat <= 7'(min_l + rem_nx);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lancer_de.sv
// tb_lancer_de: randomized bench for lancer_de with a cycle-level
// reference model and a valide-driven scoreboard.
module tb_lancer_de;

  localparam int          D = 8;
  localparam logic [15:0] G = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lancer = 1'b0;
  logic [6:0] min_de = '0;
  logic [6:0] max_de = '0;
  logic [6:0] resultat;
  logic       valide;
  logic       occupe;

  lancer_de #(.DUREE_ROULE(D), .GRAINE(G)) dut (
    .clk(clk),
    .reset(reset),
    .lancer(lancer),
    .min_de(min_de),
    .max_de(max_de),
    .resultat(resultat),
    .valide(valide),
    .occupe(occupe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   res_log[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rolls_exp = 0;
  int   rolls_seen = 0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d required %0d (cycle %0d)",
                 name, act, req, cyc);
    end
  endfunction

  // Reference model: tracks roll phase in cycles since the press.
  logic [15:0] m_lfsr = G;
  logic        m_lan_prev = 1'b0;
  bit          m_busy = 0;
  bit          m_aff = 0;
  int          t0 = 0;
  int          m_min = 0;
  int          m_max = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_lfsr = G;
      m_lan_prev = 1'b0;
      m_busy = 0;
      m_aff = 0;
      rolls_exp -= sb.size();
      sb.delete();
    end else begin
      if (lancer && !m_lan_prev && !m_busy) begin
        m_busy = 1;
        m_aff = 0;
        t0 = cyc;
        m_min = int'(min_de);
        m_max = int'(max_de);
      end
      if (m_busy && cyc == t0 + D) begin
        int sp;
        exp_t e;
        sp = (m_max >= m_min) ? m_max - m_min + 1 : 1;
        e.val = m_min + (int'(m_lfsr[13:0]) % sp);
        e.due = t0 + D + 15;
        sb.push_back(e);
        rolls_exp++;
      end
      if (m_busy && cyc == t0 + D + 14) begin
        m_busy = 0;
        m_aff = 1;
      end
      m_lfsr = {1'b0, m_lfsr[15:1]}
             ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_lan_prev = lancer;
    end
    cyc++;
  end

  // Monitor: per-cycle status checks, pops on valide rising.
  logic val_prev = 1'b0;
  int   last_val = 0;

  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      val_prev = 1'b0;
    end else begin
      chk("occupe", int'(occupe), int'(m_busy));
      chk("valide", int'(valide), int'(m_aff));
      if (valide && !val_prev) begin
        rolls_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_valide", int'(valide), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resultat", int'(resultat), e.val);
          chk("latency", cyc, e.due);
          last_val = e.val;
        end
        res_log.push_back(int'(resultat));
      end else if (valide) begin
        chk("hold", int'(resultat), last_val);
      end
`ifndef LANCER_ANIM_EN
      else begin
        chk("idle_zero", int'(resultat), 0);
      end
`endif
      val_prev = valide;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    lancer = 1'b1;
    repeat (hold) @(negedge clk);
    lancer = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!valide && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("roll_done", int'(valide), 1);
  endtask

  initial begin
    int base;
    int face[7];
    int gt4;
    bit range_ok;

    wait_n(3);
    chk("rst_resultat", int'(resultat), 0);
    chk("rst_valide", int'(valide), 0);
    chk("rst_occupe", int'(occupe), 0);
    reset = 1'b0;
    wait_n(2);

    // Single-face die
    min_de = 7'd4; max_de = 7'd4;
    press(1);
    wait_done();
    chk("min_eq_max", int'(resultat), 4);

    // Inverted bounds
    min_de = 7'd5; max_de = 7'd3;
    press(1);
    wait_done();
    chk("inverted", int'(resultat), 5);

    // Held button: one roll only
    min_de = 7'd2; max_de = 7'd9;
    press(60);
    wait_done();
    wait_n(5);

    // Presses during ROULE and REDUIT, then in AFFICHE
    min_de = 7'd1; max_de = 7'd20;
    press(1);
    wait_n(3);
    press(1);
    wait_n(4);
    press(1);
    wait_done();
    press(1);
    chk("affiche_drop", int'(valide), 0);
    wait_done();

    // Fair d6
    min_de = 7'd1; max_de = 7'd6;
    base = res_log.size();
    for (int i = 0; i < 1500; i++) begin
      press(1);
      wait_done();
      wait_n($urandom_range(0, 7));
    end
    chk("d6_pulses", res_log.size() - base, 1500);
    for (int f = 0; f < 7; f++) face[f] = 0;
    range_ok = 1;
    for (int i = base; i < res_log.size(); i++) begin
      if (res_log[i] < 1 || res_log[i] > 6) range_ok = 0;
      else face[res_log[i]]++;
    end
    chk("d6_range", int'(range_ok), 1);
    for (int f = 1; f <= 6; f++)
      chk($sformatf("d6_face%0d_ge150", f),
          int'(face[f] >= 150), 1);

    // Bounds change after latch is ignored
    base = res_log.size();
    for (int i = 0; i < 200; i++) begin
      min_de = 7'd1; max_de = 7'd100;
      press(1);
      @(negedge clk);
      max_de = 7'd4;
      wait_done();
      wait_n($urandom_range(0, 3));
    end
    gt4 = 0;
    range_ok = 1;
    for (int i = base; i < res_log.size(); i++) begin
      if (res_log[i] > 4) gt4++;
      if (res_log[i] < 1 || res_log[i] > 100) range_ok = 0;
    end
    chk("d100_range", int'(range_ok), 1);
    chk("d100_gt4", int'(gt4 > 0), 1);

    // Random bounds, including inverted pairs
    for (int i = 0; i < 30; i++) begin
      min_de = 7'($urandom_range(0, 100));
      max_de = 7'($urandom_range(0, 100));
      press(1);
      wait_done();
      wait_n($urandom_range(0, 5));
    end

    // Reset in the middle of ROULE
    min_de = 7'd1; max_de = 7'd6;
    press(1);
    wait_n(4);
    reset = 1'b1;
    #1;
    chk("midrst_resultat", int'(resultat), 0);
    chk("midrst_valide", int'(valide), 0);
    chk("midrst_occupe", int'(occupe), 0);
    wait_n(3);
    reset = 1'b0;
    wait_n(2);
    press(1);
    wait_done();

    wait_n(3);
    chk("sb_empty", sb.size(), 0);
    chk("roll_count", rolls_seen, rolls_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
